// File: rtl/u_rx_ctrl.sv
// u_rx_ctrl: receive-side controller for the UART receiver.
// It qualifies characters from the receiver's ready level and rejects false starts
// when the low period is shorter than MIN_LOW. Accepted bytes are buffered in a
// first-word-fall-through FIFO that a valid/ready consumer drains.
// The FIFO reports an overflow through the sticky ovf_errH.
// Optional feature macro: RXC_TIMEOUT_EN adds an idle timeout on a non-empty FIFO.
// Without the macro, timeoutH is tied to 0.
module u_rx_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = 2,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned MIN_LOW     = 32,
  parameter int unsigned TIMEOUT_CYC = 640
) (
  input  logic             sys_clk,
  input  logic             sys_rstH,
  input  logic [7:0]       rec_dataH,
  input  logic             rec_readyH,
  output logic [7:0]       out_dataH,
  output logic             out_validH,
  input  logic             out_readyH,
  output logic [CNT_W-1:0] fifo_cntH,
  output logic             ovf_errH,
  input  logic             ovf_clrH,
  output logic             false_stH,
  output logic             timeoutH
);

  localparam int unsigned      LOW_W     = 8;
  localparam logic [LOW_W-1:0] LOW_MAX   = '1;
  localparam logic [LOW_W-1:0] MIN_LOW_V = LOW_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } rxState_t;

  rxState_t         state;
  logic [LOW_W-1:0] lowCnt;
  logic             pushReq;
  logic [7:0]       pushData;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  logic             fifoFull;
  logic             doPop;
  logic             doPush;
  logic             doDrop;
  logic [PTR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0] cntNext;
  logic [7:0]       headNext;

  // Character qualification FSM; an accepted byte becomes a registered push request
  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      state     <= SYNC;
      lowCnt    <= '0;
      pushReq   <= 1'b0;
      pushData  <= 8'h00;
      false_stH <= 1'b0;
    end else begin
      pushReq   <= 1'b0;
      false_stH <= 1'b0;
      case (state)
        // Swallow the receiver's own post-reset low-to-high transition
        SYNC: begin
          if (rec_readyH) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!rec_readyH) begin
            state  <= RECV;
            lowCnt <= LOW_W'(1);
          end
        end
        RECV: begin
          if (!rec_readyH) begin
            if (lowCnt != LOW_MAX) begin
              lowCnt <= lowCnt + LOW_W'(1);
            end
          end else begin
            state <= IDLE;
            if (lowCnt >= MIN_LOW_V) begin
              pushReq  <= 1'b1;
              pushData <= rec_dataH;
            end else begin
              false_stH <= 1'b1;
            end
          end
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

  // FIFO control: push/pop qualification, next count and next head byte
  always_comb begin
    fifoFull  = (fifo_cntH == FULL_CNT);
    doPop     = out_validH & out_readyH;
    doPush    = pushReq & (~fifoFull | doPop);
    doDrop    = pushReq & fifoFull & ~doPop;
    rdPtrNext = doPop ? rdPtr + PTR_W'(1) : rdPtr;
    cntNext   = fifo_cntH;
    if (doPush && !doPop) begin
      cntNext = fifo_cntH + CNT_W'(1);
    end else if (!doPush && doPop) begin
      cntNext = fifo_cntH - CNT_W'(1);
    end
    // The head holds its last value once the FIFO drains; a byte written into
    // the head slot this cycle bypasses the storage array
    headNext = out_dataH;
    if (cntNext != '0) begin
      if (doPush && (wrPtr == rdPtrNext)) begin
        headNext = pushData;
      end else begin
        headNext = mem[rdPtrNext];
      end
    end
  end

  // FIFO storage array; contents need no reset since the pointers define validity
  always_ff @(posedge sys_clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // FIFO pointers, count, registered head/valid and sticky overflow flag
  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_cntH  <= '0;
      out_validH <= 1'b0;
      out_dataH  <= 8'h00;
      ovf_errH   <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      rdPtr      <= rdPtrNext;
      fifo_cntH  <= cntNext;
      out_validH <= (cntNext != '0);
      out_dataH  <= headNext;
      if (doDrop) begin
        ovf_errH <= 1'b1;
      end else if (ovf_clrH) begin
        ovf_errH <= 1'b0;
      end
    end
  end

`ifdef RXC_TIMEOUT_EN
  localparam int unsigned IDLE_W    = 16;
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idleCnt;
  logic [IDLE_W-1:0] idleInc;
  logic              idleClr;

  // Idle-count restart conditions and the saturating increment
  always_comb begin
    idleClr = doPush | doPop | (state != IDLE) | ~rec_readyH;
    idleInc = (idleCnt == IDLE_MAX) ? idleCnt : idleCnt + IDLE_W'(1);
  end

  // Count line-idle cycles while data waits in the FIFO
  always_ff @(posedge sys_clk) begin
    if (sys_rstH || idleClr) begin
      idleCnt  <= '0;
      timeoutH <= 1'b0;
    end else if (fifo_cntH != '0) begin
      idleCnt  <= idleInc;
      timeoutH <= (idleInc >= TIMEOUT_V);
    end
  end
`else
  logic unusedTimeoutCyc;

  assign unusedTimeoutCyc = ^TIMEOUT_CYC;
  assign timeoutH         = 1'b0;
`endif

endmodule

// File: tb/tb_u_rx_ctrl.sv
// tb_u_rx_ctrl: directed bench for u_rx_ctrl.
// Stimulus queues the expected bytes in a scoreboard; a monitor compares each popped byte.
module tb_u_rx_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             sys_clk;
  logic             sys_rstH;
  logic [7:0]       rec_dataH;
  logic             rec_readyH;
  logic [7:0]       out_dataH;
  logic             out_validH;
  logic             out_readyH;
  logic [CNT_W-1:0] fifo_cntH;
  logic             ovf_errH;
  logic             ovf_clrH;
  logic             false_stH;
  logic             timeoutH;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] expQ[$];

  u_rx_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rstH   (sys_rstH),
    .rec_dataH  (rec_dataH),
    .rec_readyH (rec_readyH),
    .out_dataH  (out_dataH),
    .out_validH (out_validH),
    .out_readyH (out_readyH),
    .fifo_cntH  (fifo_cntH),
    .ovf_errH   (ovf_errH),
    .ovf_clrH   (ovf_clrH),
    .false_stH  (false_stH),
    .timeoutH   (timeoutH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Hold the line low for lowCyc sampled edges, then raise it with data stable
  task automatic sendChar(input logic [7:0] d, input int lowCyc);
    rec_dataH  = d;
    rec_readyH = 1'b0;
    repeat (lowCyc) tick();
    rec_readyH = 1'b1;
  endtask

  // Accept until the FIFO is empty, bounded
  task automatic drain();
    int n;
    n = 0;
    out_readyH = 1'b1;
    do begin
      @(negedge sys_clk);
      n++;
    end while (out_validH && n < 20);
    out_readyH = 1'b0;
    check("drain_empty", 32'(out_validH), 32'd0);
  endtask

  // Scoreboard monitor: every accepted head byte must match the oldest expected byte
  always @(negedge sys_clk) begin
    if (!sys_rstH && out_validH && out_readyH) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", out_dataH, $time);
      end else begin
        check("pop_data", 32'(out_dataH), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rstH   = 1'b1;
    rec_dataH  = 8'h00;
    rec_readyH = 1'b0;
    out_readyH = 1'b0;
    ovf_clrH   = 1'b0;
    repeat (3) tick();
    @(negedge sys_clk);
    check("rst_cnt",   32'(fifo_cntH),  32'd0);
    check("rst_valid", 32'(out_validH), 32'd0);
    check("rst_data",  32'(out_dataH),  32'h00);
    check("rst_ovf",   32'(ovf_errH),   32'd0);
    check("rst_false", 32'(false_stH),  32'd0);
    check("rst_tmo",   32'(timeoutH),   32'd0);

    // Test 1: receiver's post-reset rise must not produce a character
    tick();
    sys_rstH = 1'b0;
    repeat (2) tick();
    rec_readyH = 1'b1;
    repeat (4) tick();
    @(negedge sys_clk);
    check("t1_cnt",   32'(fifo_cntH),  32'd0);
    check("t1_valid", 32'(out_validH), 32'd0);
    check("t1_false", 32'(false_stH),  32'd0);

    // Test 2: valid character, two-cycle latency from the rise
    repeat (2) tick();
    sendChar(8'hA5, 150);
    expQ.push_back(8'hA5);
    tick();
    @(negedge sys_clk);
    check("t2_valid_early", 32'(out_validH), 32'd0);
    tick();
    @(negedge sys_clk);
    check("t2_valid", 32'(out_validH), 32'd1);
    check("t2_data",  32'(out_dataH),  32'hA5);
    check("t2_cnt",   32'(fifo_cntH),  32'd1);
    drain();
    check("t2_cnt_drained", 32'(fifo_cntH), 32'd0);
    check("t2_data_hold",   32'(out_dataH), 32'hA5);

    // Test 3: short low period is a false start
    repeat (2) tick();
    sendChar(8'h5A, 5);
    tick();
    @(negedge sys_clk);
    check("t3_false_pulse", 32'(false_stH), 32'd1);
    tick();
    @(negedge sys_clk);
    check("t3_false_end", 32'(false_stH),  32'd0);
    check("t3_cnt",       32'(fifo_cntH),  32'd0);
    check("t3_valid",     32'(out_validH), 32'd0);

    // Test 4: five characters into a four-deep FIFO, overflow, drain, clear
    for (int i = 1; i <= 5; i++) begin
      repeat (2) tick();
      sendChar(8'(i), 40);
      if (i <= 4) expQ.push_back(8'(i));
    end
    repeat (3) tick();
    @(negedge sys_clk);
    check("t4_cnt_full", 32'(fifo_cntH),  32'd4);
    check("t4_ovf",      32'(ovf_errH),   32'd1);
    check("t4_valid",    32'(out_validH), 32'd1);
    check("t4_head",     32'(out_dataH),  32'h01);
    drain();
    check("t4_cnt_drained", 32'(fifo_cntH), 32'd0);
    check("t4_ovf_sticky",  32'(ovf_errH),  32'd1);
    tick();
    ovf_clrH = 1'b1;
    tick();
    ovf_clrH = 1'b0;
    @(negedge sys_clk);
    check("t4_ovf_clr", 32'(ovf_errH), 32'd0);

    // Test 5: full FIFO with push and pop in the same cycle
    for (int i = 6; i <= 9; i++) begin
      repeat (2) tick();
      sendChar(8'(i), 40);
      expQ.push_back(8'(i));
    end
    repeat (3) tick();
    @(negedge sys_clk);
    check("t5_cnt_full", 32'(fifo_cntH), 32'd4);
    tick();
    sendChar(8'h0A, 40);
    expQ.push_back(8'h0A);
    tick();
    out_readyH = 1'b1;
    tick();
    out_readyH = 1'b0;
    @(negedge sys_clk);
    check("t5_cnt_same", 32'(fifo_cntH), 32'd4);
    check("t5_ovf",      32'(ovf_errH),  32'd0);
    check("t5_head",     32'(out_dataH), 32'h07);
    drain();
    check("t5_cnt_drained", 32'(fifo_cntH), 32'd0);

    // Reset in the middle of a character: nothing may be pushed afterwards
    repeat (2) tick();
    rec_dataH  = 8'hEE;
    rec_readyH = 1'b0;
    repeat (50) tick();
    sys_rstH = 1'b1;
    repeat (2) tick();
    sys_rstH = 1'b0;
    tick();
    rec_readyH = 1'b1;
    tick();
    @(negedge sys_clk);
    check("rm_false", 32'(false_stH), 32'd0);
    repeat (3) tick();
    @(negedge sys_clk);
    check("rm_cnt",   32'(fifo_cntH),  32'd0);
    check("rm_valid", 32'(out_validH), 32'd0);

    // Test 6: idle timeout with one byte held
    repeat (2) tick();
    sendChar(8'h0B, 40);
    expQ.push_back(8'h0B);
    repeat (2) tick();
    repeat (630) tick();
    @(negedge sys_clk);
    check("t6_tmo_early", 32'(timeoutH), 32'd0);
    repeat (15) tick();
    @(negedge sys_clk);
`ifdef RXC_TIMEOUT_EN
    check("t6_tmo_set", 32'(timeoutH), 32'd1);
`else
    check("t6_tmo_tied", 32'(timeoutH), 32'd0);
`endif
    check("t6_cnt", 32'(fifo_cntH), 32'd1);
    drain();
    check("t6_tmo_clr", 32'(timeoutH), 32'd0);

    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
